// File: rtl/ghost_collision.sv
// ghost_collision: Pac-Man versus ghost overlap detection plus the
// lives / death-freeze / game-over state machine.
//
// Stage 1 registers a per-ghost overlap vector every cycle. Stage 2 is the
// game-state FSM, which looks at that vector only on frame strobes.
//
// Optional build macro: GHOST_COLLISION_GODMODE_EN
//   When defined, a hit in PLAYING only latches hit_ghost. Lives and state
//   are left alone, so the death path is never entered after start.
module ghost_collision #(
  parameter int HIT_RADIUS   = 6,
  parameter int LIVES        = 3,
  parameter int DEATH_FRAMES = 90
) (
  input  logic       vga_pix_clk,
  input  logic       rst,
  input  logic       frame_stb,
  input  logic       start,
  input  logic [8:0] x_pac,
  input  logic [8:0] y_pac,
  input  logic [8:0] x_red,
  input  logic [8:0] y_red,
  input  logic [8:0] x_blue,
  input  logic [8:0] y_blue,
  input  logic [8:0] x_yellow,
  input  logic [8:0] y_yellow,
  input  logic [8:0] x_pink,
  input  logic [8:0] y_pink,
  output logic       freeze,
  output logic       respawn,
  output logic [1:0] lives,
  output logic       game_over,
  output logic [3:0] hit_ghost,
  output logic [2:0] state
);

  // Parameters resized once so every compare below is width-matched.
  localparam logic [9:0] HIT_R      = 10'(HIT_RADIUS);
  localparam logic [1:0] LIVES_INIT = 2'(LIVES);
  localparam logic [7:0] DEATH_LIM  = 8'(DEATH_FRAMES);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PLAYING   = 3'd1,
    ST_DYING     = 3'd2,
    ST_RESPAWN   = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_t;

  // Per-axis closeness test. The difference is taken as a 10-bit two's
  // complement value so the 9-bit coordinates never overflow, and there is
  // deliberately no wrap-around: the tunnel edges are far apart.
  function automatic logic axis_near(input logic [8:0] a, input logic [8:0] b);
    logic [9:0] diff;
    logic [9:0] mag;
    diff = {1'b0, a} - {1'b0, b};
    mag  = diff[9] ? (~diff + 10'd1) : diff;
    return (mag < HIT_R);
  endfunction

  logic [3:0] hit_d, hit_q;

  state_t     state_q, state_d;
  logic       freeze_q, freeze_d;
  logic       respawn_q, respawn_d;
  logic [1:0] lives_q, lives_d;
  logic       game_over_q, game_over_d;
  logic [3:0] hit_ghost_q, hit_ghost_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] cnt_inc;

  // Stage 1: overlap vector {pink, yellow, blue, red} from current positions.
  always_comb begin
    hit_d    = 4'b0000;
    hit_d[0] = axis_near(x_pac, x_red)    && axis_near(y_pac, y_red);
    hit_d[1] = axis_near(x_pac, x_blue)   && axis_near(y_pac, y_blue);
    hit_d[2] = axis_near(x_pac, x_yellow) && axis_near(y_pac, y_yellow);
    hit_d[3] = axis_near(x_pac, x_pink)   && axis_near(y_pac, y_pink);
  end

  // Stage 1 register: hit vector lags positions by one cycle.
  always_ff @(posedge vga_pix_clk) begin
    if (rst) hit_q <= 4'b0000;
    else     hit_q <= hit_d;
  end

  // Stage 2 next-state and next-output logic; every output is precomputed
  // here so that it comes straight out of a flop.
  always_comb begin
    state_d     = state_q;
    freeze_d    = freeze_q;
    respawn_d   = 1'b0;
    lives_d     = lives_q;
    game_over_d = game_over_q;
    hit_ghost_d = hit_ghost_q;
    cnt_d       = cnt_q;
    cnt_inc     = cnt_q + 8'd1;

    case (state_q)
      ST_IDLE: begin
        freeze_d = 1'b1;
        if (start) begin
          respawn_d = 1'b1;
          freeze_d  = 1'b0;
          state_d   = ST_PLAYING;
        end
      end

      ST_PLAYING: begin
        freeze_d = 1'b0;
        if (frame_stb && (hit_q != 4'b0000)) begin
          hit_ghost_d = hit_q;
`ifdef GHOST_COLLISION_GODMODE_EN
          state_d     = ST_PLAYING;
`else
          lives_d     = lives_q - 2'd1;
          cnt_d       = 8'd0;
          freeze_d    = 1'b1;
          state_d     = ST_DYING;
`endif
        end
      end

      ST_DYING: begin
        freeze_d = 1'b1;
        if (frame_stb) begin
          cnt_d = cnt_inc;
          if (cnt_inc == DEATH_LIM) begin
            if (lives_q == 2'd0) begin
              game_over_d = 1'b1;
              state_d     = ST_GAME_OVER;
            end else begin
              respawn_d = 1'b1;
              state_d   = ST_RESPAWN;
            end
          end
        end
      end

      ST_RESPAWN: begin
        freeze_d = 1'b0;
        state_d  = ST_PLAYING;
      end

      ST_GAME_OVER: begin
        freeze_d    = 1'b1;
        game_over_d = 1'b1;
        if (start) begin
          lives_d     = LIVES_INIT;
          hit_ghost_d = 4'b0000;
          respawn_d   = 1'b1;
          freeze_d    = 1'b0;
          game_over_d = 1'b0;
          state_d     = ST_PLAYING;
        end
      end

      default: begin
        freeze_d    = 1'b1;
        game_over_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // Stage 2 register: FSM state, frame counter and all registered outputs.
  always_ff @(posedge vga_pix_clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      freeze_q    <= 1'b1;
      respawn_q   <= 1'b0;
      lives_q     <= LIVES_INIT;
      game_over_q <= 1'b0;
      hit_ghost_q <= 4'b0000;
      cnt_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      freeze_q    <= freeze_d;
      respawn_q   <= respawn_d;
      lives_q     <= lives_d;
      game_over_q <= game_over_d;
      hit_ghost_q <= hit_ghost_d;
      cnt_q       <= cnt_d;
    end
  end

  assign freeze    = freeze_q;
  assign respawn   = respawn_q;
  assign lives     = lives_q;
  assign game_over = game_over_q;
  assign hit_ghost = hit_ghost_q;
  assign state     = state_q;

endmodule

// File: tb/tb_ghost_collision.sv
// Self-checking bench for ghost_collision: expected output vectors are pushed
// to a scoreboard queue as stimulus is driven and popped after each edge.
module tb_ghost_collision;

  localparam int LIVES_P  = 3;
  localparam int FRAMES_P = 90;

  logic       vga_pix_clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_stb = 1'b0;
  logic       start = 1'b0;
  logic [8:0] x_pac = 9'd120, y_pac = 9'd112;
  logic [8:0] x_red = 9'd10,  y_red = 9'd10;
  logic [8:0] x_blue = 9'd300, y_blue = 9'd10;
  logic [8:0] x_yellow = 9'd10, y_yellow = 9'd200;
  logic [8:0] x_pink = 9'd300, y_pink = 9'd200;
  logic       freeze, respawn, game_over;
  logic [1:0] lives;
  logic [3:0] hit_ghost;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [11:0] exp;
  } exp_t;
  exp_t sb_q[$];

  ghost_collision #(
    .HIT_RADIUS(6),
    .LIVES(LIVES_P),
    .DEATH_FRAMES(FRAMES_P)
  ) dut (
    .vga_pix_clk(vga_pix_clk),
    .rst(rst),
    .frame_stb(frame_stb),
    .start(start),
    .x_pac(x_pac), .y_pac(y_pac),
    .x_red(x_red), .y_red(y_red),
    .x_blue(x_blue), .y_blue(y_blue),
    .x_yellow(x_yellow), .y_yellow(y_yellow),
    .x_pink(x_pink), .y_pink(y_pink),
    .freeze(freeze),
    .respawn(respawn),
    .lives(lives),
    .game_over(game_over),
    .hit_ghost(hit_ghost),
    .state(state)
  );

  always #5 vga_pix_clk = ~vga_pix_clk;

  // Safety net so the run always ends even if something stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached, observed no $finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Vector layout {state[2:0], freeze, respawn, lives[1:0], game_over, hit_ghost[3:0]}.
  function automatic logic [11:0] pack(input logic [2:0] st, input logic fr, input logic rs,
                                       input logic [1:0] lv, input logic go, input logic [3:0] hg);
    return {st, fr, rs, lv, go, hg};
  endfunction

  task automatic checkOutput(input string tag, input logic [11:0] observed, input logic [11:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got st=%0d fr=%b rs=%b lv=%0d go=%b hg=%b, need st=%0d fr=%b rs=%b lv=%0d go=%b hg=%b",
               tag, observed[11:9], observed[8], observed[7], observed[6:5], observed[4], observed[3:0],
               expected[11:9], expected[8], expected[7], expected[6:5], expected[4], expected[3:0]);
    end
  endtask

  // Push the expectation for the edge about to happen, clock it, then
  // pop and compare one delay unit after the edge.
  task automatic applyStimulus(input string tag, input logic [2:0] st, input logic fr, input logic rs,
                               input logic [1:0] lv, input logic go, input logic [3:0] hg);
    exp_t e;
    e.tag = tag;
    e.exp = pack(st, fr, rs, lv, go, hg);
    sb_q.push_back(e);
    @(posedge vga_pix_clk);
    #1;
    e = sb_q.pop_front();
    checkOutput(e.tag, {state, freeze, respawn, lives, game_over, hit_ghost}, e.exp);
  endtask

  // n frame strobes (3-cycle period) while DYING is expected to persist.
  task automatic dyingStrobes(input int n, input logic [1:0] lv, input logic [3:0] hg);
    for (int i = 0; i < n; i++) begin
      frame_stb = 1'b1;
      applyStimulus("dying_stb", 3'd2, 1'b1, 1'b0, lv, 1'b0, hg);
      frame_stb = 1'b0;
      applyStimulus("dying_gap", 3'd2, 1'b1, 1'b0, lv, 1'b0, hg);
      applyStimulus("dying_gap", 3'd2, 1'b1, 1'b0, lv, 1'b0, hg);
    end
  endtask

  task automatic ghostsFar();
    x_red = 9'd10;     y_red = 9'd10;
    x_blue = 9'd300;   y_blue = 9'd10;
    x_yellow = 9'd10;  y_yellow = 9'd200;
    x_pink = 9'd300;   y_pink = 9'd200;
  endtask

  initial begin
    // Reset state.
    applyStimulus("reset0", 3'd0, 1'b1, 1'b0, 2'(LIVES_P), 1'b0, 4'b0000);
    applyStimulus("reset1", 3'd0, 1'b1, 1'b0, 2'(LIVES_P), 1'b0, 4'b0000);
    rst = 1'b0;
    applyStimulus("idle_hold", 3'd0, 1'b1, 1'b0, 2'd3, 1'b0, 4'b0000);

    // Start: one respawn pulse then PLAYING.
    start = 1'b1;
    applyStimulus("start_resp", 3'd1, 1'b0, 1'b1, 2'd3, 1'b0, 4'b0000);
    start = 1'b0;
    applyStimulus("start_play", 3'd1, 1'b0, 1'b0, 2'd3, 1'b0, 4'b0000);

    // |dx| = 6 is not a hit.
    x_red = 9'd126; y_red = 9'd112;
    applyStimulus("edge6_settle", 3'd1, 1'b0, 1'b0, 2'd3, 1'b0, 4'b0000);
    frame_stb = 1'b1;
    applyStimulus("edge6_nohit", 3'd1, 1'b0, 1'b0, 2'd3, 1'b0, 4'b0000);
    frame_stb = 1'b0;
    // |dy| = 6 on the negative side is not a hit either.
    x_red = 9'd120; y_red = 9'd118;
    applyStimulus("dy6_settle", 3'd1, 1'b0, 1'b0, 2'd3, 1'b0, 4'b0000);
    applyStimulus("dy6_gap", 3'd1, 1'b0, 1'b0, 2'd3, 1'b0, 4'b0000);
    frame_stb = 1'b1;
    applyStimulus("dy6_nohit", 3'd1, 1'b0, 1'b0, 2'd3, 1'b0, 4'b0000);
    frame_stb = 1'b0;

    // Hit without a strobe must not act.
    x_red = 9'd125; y_red = 9'd112;
    applyStimulus("hit_settle", 3'd1, 1'b0, 1'b0, 2'd3, 1'b0, 4'b0000);
    applyStimulus("hit_nostb", 3'd1, 1'b0, 1'b0, 2'd3, 1'b0, 4'b0000);
    frame_stb = 1'b1;
`ifdef GHOST_COLLISION_GODMODE_EN
    applyStimulus("god_hit", 3'd1, 1'b0, 1'b0, 2'd3, 1'b0, 4'b0001);
    frame_stb = 1'b0;
    applyStimulus("god_hold", 3'd1, 1'b0, 1'b0, 2'd3, 1'b0, 4'b0001);
`else
    applyStimulus("red_hit", 3'd2, 1'b1, 1'b0, 2'd2, 1'b0, 4'b0001);
    frame_stb = 1'b0;
    ghostsFar();
    start = 1'b1;
    applyStimulus("dying_start_ign", 3'd2, 1'b1, 1'b0, 2'd2, 1'b0, 4'b0001);
    start = 1'b0;
    applyStimulus("dying_gap0", 3'd2, 1'b1, 1'b0, 2'd2, 1'b0, 4'b0001);
    dyingStrobes(FRAMES_P - 1, 2'd2, 4'b0001);
    frame_stb = 1'b1;
    applyStimulus("respawn1", 3'd3, 1'b1, 1'b1, 2'd2, 1'b0, 4'b0001);
    frame_stb = 1'b0;
    applyStimulus("replay1", 3'd1, 1'b0, 1'b0, 2'd2, 1'b0, 4'b0001);

    // Red and pink together: both bits, one life.
    x_red = 9'd120; y_red = 9'd112; x_pink = 9'd120; y_pink = 9'd112;
    applyStimulus("dual_settle", 3'd1, 1'b0, 1'b0, 2'd2, 1'b0, 4'b0001);
    frame_stb = 1'b1;
    applyStimulus("dual_hit", 3'd2, 1'b1, 1'b0, 2'd1, 1'b0, 4'b1001);
    frame_stb = 1'b0;
    ghostsFar();
    applyStimulus("dual_gap0", 3'd2, 1'b1, 1'b0, 2'd1, 1'b0, 4'b1001);
    applyStimulus("dual_gap1", 3'd2, 1'b1, 1'b0, 2'd1, 1'b0, 4'b1001);
    dyingStrobes(FRAMES_P - 1, 2'd1, 4'b1001);
    frame_stb = 1'b1;
    applyStimulus("respawn2", 3'd3, 1'b1, 1'b1, 2'd1, 1'b0, 4'b1001);
    frame_stb = 1'b0;
    applyStimulus("replay2", 3'd1, 1'b0, 1'b0, 2'd1, 1'b0, 4'b1001);

    // Blue diagonal at (-4,-4): last life.
    x_blue = 9'd116; y_blue = 9'd108;
    applyStimulus("blue_settle", 3'd1, 1'b0, 1'b0, 2'd1, 1'b0, 4'b1001);
    frame_stb = 1'b1;
    applyStimulus("blue_hit", 3'd2, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0010);
    frame_stb = 1'b0;
    ghostsFar();
    applyStimulus("blue_gap0", 3'd2, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0010);
    applyStimulus("blue_gap1", 3'd2, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0010);
    dyingStrobes(FRAMES_P - 1, 2'd0, 4'b0010);
    frame_stb = 1'b1;
    applyStimulus("game_over", 3'd4, 1'b1, 1'b0, 2'd0, 1'b1, 4'b0010);
    frame_stb = 1'b0;
    applyStimulus("game_over_hold", 3'd4, 1'b1, 1'b0, 2'd0, 1'b1, 4'b0010);

    // Restart from GAME_OVER.
    start = 1'b1;
    applyStimulus("restart", 3'd1, 1'b0, 1'b1, 2'd3, 1'b0, 4'b0000);
    start = 1'b0;
    applyStimulus("restart_play", 3'd1, 1'b0, 1'b0, 2'd3, 1'b0, 4'b0000);

    // Yellow hit, then reset at strobe 40 of DYING.
    x_yellow = 9'd120; y_yellow = 9'd112;
    applyStimulus("yel_settle", 3'd1, 1'b0, 1'b0, 2'd3, 1'b0, 4'b0000);
    frame_stb = 1'b1;
    applyStimulus("yel_hit", 3'd2, 1'b1, 1'b0, 2'd2, 1'b0, 4'b0100);
    frame_stb = 1'b0;
    ghostsFar();
    applyStimulus("yel_gap0", 3'd2, 1'b1, 1'b0, 2'd2, 1'b0, 4'b0100);
    applyStimulus("yel_gap1", 3'd2, 1'b1, 1'b0, 2'd2, 1'b0, 4'b0100);
    dyingStrobes(39, 2'd2, 4'b0100);
    frame_stb = 1'b1;
    rst = 1'b1;
    applyStimulus("mid_reset", 3'd0, 1'b1, 1'b0, 2'd3, 1'b0, 4'b0000);
    frame_stb = 1'b0;
    rst = 1'b0;
    applyStimulus("post_reset", 3'd0, 1'b1, 1'b0, 2'd3, 1'b0, 4'b0000);
`endif

    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending entries, need 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ghost_collision.md
# ghost_collision

Game-state stage downstream of the ghost and Pac-Man movement blocks. Each frame it compares Pac-Man's position against all four ghost positions and detects overlap. It also runs the lives / death-freeze / game-over state machine. Its `freeze` and `respawn` outputs feed back to the movement blocks, and its `lives` and `game_over` outputs feed the sprite/HUD drawing logic.

## Interface
Parameters:
- `HIT_RADIUS`, default 6: overlap threshold in pixels, per axis. Legal range 1..15.
- `LIVES`, default 3: lives loaded at reset and at restart. Legal range 1..3.
- `DEATH_FRAMES`, default 90: length of the death freeze, in frame strobes. Legal range 1..255.

Ports:
- `vga_pix_clk`  in  1  pixel clock. Reset is `rst`, synchronous, active-high; clock is `vga_pix_clk`.
- `rst`  in  1  synchronous active-high reset.
- `frame_stb`  in  1  one-cycle pulse per frame.
- `start`  in  1  level; debounced start button.
- `x_pac`, `y_pac`  in  9 each  Pac-Man top-left, in pixels.
- `x_red`, `y_red`, `x_blue`, `y_blue`, `x_yellow`, `y_yellow`, `x_pink`, `y_pink`  in  9 each  ghost top-left coordinates.
- `freeze`  out  1  high means the movement blocks hold their positions.
- `respawn`  out  1  one-cycle pulse; movement blocks reload their start positions.
- `lives`  out  2  remaining lives.
- `game_over`  out  1  high while in GAME_OVER.
- `hit_ghost`  out  4  last collision vector, bits {pink, yellow, blue, red} = [3:0].
- `state`  out  3  encoded FSM state, for debug.

## Operation
- Stage 1 runs every cycle. For each ghost g it computes `dx = x_pac - x_g` and `dy = y_pac - y_g` as 10-bit signed values and takes their absolute values. It registers `hit_q[g] = (|dx| < HIT_RADIUS) && (|dy| < HIT_RADIUS)`. There is no screen wrap-around: the tunnel edges are treated as far apart.
- Stage 2 is the FSM. It acts on `hit_q` only in cycles where `frame_stb` = 1.
- FSM states and encoding:
  - IDLE = 0: freeze = 1. When `start` = 1, pulse `respawn` and go to PLAYING.
  - PLAYING = 1: freeze = 0. On a `frame_stb` cycle with `hit_q != 0`: latch `hit_ghost <= hit_q`, set `lives <= lives - 1`, clear the frame counter, and go to DYING.
  - DYING = 2: freeze = 1. The frame counter increments on each `frame_stb`. When it reaches `DEATH_FRAMES`, go to GAME_OVER if `lives == 0`, otherwise go to RESPAWN.
  - RESPAWN = 3: stays exactly one cycle with `respawn` = 1 and freeze = 1, then goes to PLAYING.
  - GAME_OVER = 4: freeze = 1, game_over = 1. When `start` = 1, set `lives <= LIVES`, clear `hit_ghost`, pulse `respawn`, and go to PLAYING.
- If several ghosts are hit in the same frame, all their bits are set in `hit_ghost`, but only one life is lost.
- `start` is ignored in PLAYING, DYING and RESPAWN.
- `lives` never underflows: the decrement happens only on the PLAYING→DYING transition, and `lives` ≥ 1 is guaranteed there.
- Values of `hit_ghost` and the ghost positions seen while frozen are ignored.

## Timing
- Reset values: state = IDLE, freeze = 1, respawn = 0, lives = LIVES, game_over = 0, hit_ghost = 0, frame counter = 0.
- `rst` has priority over every other event in any state. Reset in the middle of DYING returns to IDLE with lives restored to `LIVES`.
- Detection latency: positions valid at cycle N produce `hit_q` at N+1. If `frame_stb` is high at N+1, `state` = DYING and `freeze` = 1 at N+2.
- All outputs are registered. `respawn` goes high in the cycle after the `start` sample, or in the RESPAWN cycle.
- A `frame_stb` occurring in the same cycle as entry to DYING is not counted. The freeze therefore lasts exactly `DEATH_FRAMES` strobes after entry.
- The `frame_stb` period is at least 3 cycles; the movement blocks update their positions in the `frame_stb` cycle.

## Configuration
- `GHOST_COLLISION_GODMODE_EN`
- Defined: in PLAYING, a hit latches `hit_ghost` but does not change `lives` or the state. DYING, RESPAWN and GAME_OVER become unreachable after start.
- Undefined: behaviour is exactly as described in Operation.

## Test plan
- Reset, then `start` = 1 for one cycle → `respawn` pulses once, `state` = 1, `freeze` = 0, `lives` = 3.
- PLAYING with pac (120,112) and red (125,112), then `frame_stb` → `hit_ghost` = 4'b0001, `lives` = 2, `state` = 2, `freeze` = 1. With pac (120,112) and red (126,112), |dx| = 6 → no hit.
- Red and pink both at the pac position on the same strobe → `hit_ghost` = 4'b1001, `lives` decrements by exactly 1. After 90 strobes: one-cycle RESPAWN with `respawn` = 1, then PLAYING.
- Three deaths → after the third freeze `state` = 4 and `game_over` = 1. Then `start` → `lives` = 3, `hit_ghost` = 0, `respawn` pulse, `state` = 1.
- Assert `rst` at strobe 40 of DYING → next cycle `state` = 0, `lives` = 3, `freeze` = 1, `respawn` = 0.
- With `GHOST_COLLISION_GODMODE_EN` defined, the overlap from the second scenario → `hit_ghost` = 4'b0001, `lives` stays 3, `state` stays 1.
